module_display_scan: RTL and testbench



---
 rtl/module_display_scan.sv | 122 ++++++++++++
 tb/tb_module_display_scan.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_display_scan.sv
// Time-multiplexed scan driver for an N-digit 7-segment display.
// Display words are accepted into a holding register and applied only at frame boundaries.
module module_display_scan #(
    parameter int N_DIGITS         = 4,
    parameter int REFRESH_DIV      = 27000,
    parameter int ANODE_ACTIVE_LOW = 1,
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value_i,
    input  logic                  value_valid_i,
    output logic                  value_ready_o,
    input  logic                  blank_lz_i,
    output logic [3:0]            data_o,
    output logic [N_DIGITS-1:0]   anode_o,
    output logic                  blank_o,
    output logic [IDX_W-1:0]      digit_idx_o
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ANODE_OFF =
        (ANODE_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] active_q, active_d;
    logic [4*N_DIGITS-1:0] pending_q, pending_d;
    logic                  pendingFull_q, pendingFull_d;
    logic                  ready_q;
    logic [3:0]            data_q, data_d;
    logic [N_DIGITS-1:0]   anode_q, anode_d;
    logic                  blank_q;
    logic [IDX_W-1:0]      digitIdx_q;

    logic                  cntWrap;
    logic                  frameEnd;
    logic                  transfer;
    logic [3:0]            digitSel;
    logic                  leadZero;
    logic                  blankDigit;
    logic [N_DIGITS-1:0]   anodeOn;

    always_comb begin
        cntWrap  = (cnt_q == CNT_LAST);
        frameEnd = cntWrap && (idx_q == IDX_LAST);
        transfer = value_valid_i && ready_q;

        cnt_d = cntWrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cntWrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // A word accepted on the boundary edge itself waits for the next boundary.
        active_d      = active_q;
        pending_d     = pending_q;
        pendingFull_d = pendingFull_q;
        if (frameEnd && pendingFull_q) begin
            active_d      = pending_q;
            pendingFull_d = 1'b0;
        end
        if (transfer) begin
            pending_d     = value_i;
            pendingFull_d = 1'b1;
        end

        digitSel = 4'h0;
        leadZero = 1'b1;
        anodeOn  = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            anodeOn[k] = (IDX_W'(k) == idx_q);
            if (IDX_W'(k) == idx_q) begin
                digitSel = active_q[4*k +: 4];
            end
            if ((IDX_W'(k) >= idx_q) && (active_q[4*k +: 4] != 4'h0)) begin
                leadZero = 1'b0;
            end
        end

        // Digit 0 is never blanked so an all-zero word still reads "0".
        blankDigit = blank_lz_i && (idx_q != '0) && leadZero;
        data_d     = blankDigit ? 4'h0 : digitSel;
        anode_d    = blankDigit ? ANODE_OFF
                   : ((ANODE_ACTIVE_LOW != 0) ? ~anodeOn : anodeOn);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            active_q      <= '0;
            pending_q     <= '0;
            pendingFull_q <= 1'b0;
            ready_q       <= 1'b0;
            data_q        <= 4'h0;
            anode_q       <= ANODE_OFF;
            blank_q       <= 1'b1;
            digitIdx_q    <= '0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pendingFull_q <= pendingFull_d;
            ready_q       <= !pendingFull_d;
            data_q        <= data_d;
            anode_q       <= anode_d;
            blank_q       <= blankDigit;
            digitIdx_q    <= idx_q;
        end
    end

    assign value_ready_o = ready_q;
    assign data_o        = data_q;
    assign anode_o       = anode_q;
    assign blank_o       = blank_q;
    assign digit_idx_o   = digitIdx_q;

endmodule

// File: tb/tb_module_display_scan.sv
// Self-checking bench for module_display_scan with N_DIGITS=4, REFRESH_DIV=4, active-low anodes.
// A cycle-level reference model derives every expected output from the display rules.
module tb_module_display_scan;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_i;
    logic        value_valid_i;
    logic        value_ready_o;
    logic        blank_lz_i;
    logic [3:0]  data_o;
    logic [3:0]  anode_o;
    logic        blank_o;
    logic [1:0]  digit_idx_o;

    int total = 0;
    int bad   = 0;

    module_display_scan #(
        .N_DIGITS(N),
        .REFRESH_DIV(DIV),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value_i(value_i),
        .value_valid_i(value_valid_i),
        .value_ready_o(value_ready_o),
        .blank_lz_i(blank_lz_i),
        .data_o(data_o),
        .anode_o(anode_o),
        .blank_o(blank_o),
        .digit_idx_o(digit_idx_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: what each display rule says the outputs should be after every edge.
    int          mCnt;
    int          mIdx;
    logic [15:0] mActive;
    logic [15:0] mPend;
    bit          mPendFull;
    logic        expReady;
    logic [3:0]  expAnode;
    logic [3:0]  expData;
    logic        expBlank;
    logic [1:0]  expIdx;

    function automatic logic [3:0] nibbleOf(input logic [15:0] w, input int i);
        logic [15:0] s;
        s = w >> (4 * i);
        return s[3:0];
    endfunction

    function automatic bit isBlanked(input logic [15:0] w, input int i, input logic lz);
        return lz && (i != 0) && ((w >> (4 * i)) == 16'h0);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mCnt <= 0; mIdx <= 0; mActive <= '0; mPend <= '0; mPendFull <= 1'b0;
            expReady <= 1'b0; expAnode <= 4'hF; expData <= 4'h0; expBlank <= 1'b1; expIdx <= 2'd0;
        end else begin
            expIdx   <= 2'(mIdx);
            expBlank <= isBlanked(mActive, mIdx, blank_lz_i);
            expData  <= isBlanked(mActive, mIdx, blank_lz_i) ? 4'h0 : nibbleOf(mActive, mIdx);
            expAnode <= isBlanked(mActive, mIdx, blank_lz_i) ? 4'hF : 4'hF ^ (4'h1 << mIdx);
            mCnt     <= (mCnt + 1) % DIV;
            if (mCnt == DIV - 1) mIdx <= (mIdx + 1) % N;
            if (value_valid_i && expReady) begin
                mPend <= value_i; mPendFull <= 1'b1; expReady <= 1'b0;
            end else if (mCnt == DIV - 1 && mIdx == N - 1 && mPendFull) begin
                mActive <= mPend; mPendFull <= 1'b0; expReady <= 1'b1;
            end else begin
                expReady <= !mPendFull;
            end
        end
    end

    task automatic wait_wrap(output bit timedOut);
        timedOut = 1'b1;
        for (int g = 0; g < 100; g++) begin
            if (mIdx == N - 1 && mCnt == DIV - 1) begin
                timedOut = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_word(input logic [15:0] w, output bit timedOut);
        timedOut = 1'b1;
        for (int g = 0; g < 100; g++) begin
            if (value_ready_o === 1'b1) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
        end
        value_i = w;
        value_valid_i = 1'b1;
        @(negedge clk);
        value_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; value_valid_i = 1'b0; value_i = '0; blank_lz_i = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if ({anode_o, data_o, blank_o, value_ready_o, digit_idx_o} !== {4'hF, 4'h0, 1'b1, 1'b0, 2'd0}) begin
            bad++;
            $display("[TB] FAIL reset_hold: got anode=%b data=%h blank=%b ready=%b idx=%0d, want anode=1111 data=0 blank=1 ready=0 idx=0",
                     anode_o, data_o, blank_o, value_ready_o, digit_idx_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({anode_o, data_o, blank_o, value_ready_o, digit_idx_o} !== {4'b1110, 4'h0, 1'b0, 1'b1, 2'd0}) begin
            bad++;
            $display("[TB] FAIL reset_release: got anode=%b data=%h blank=%b ready=%b idx=%0d, want anode=1110 data=0 blank=0 ready=1 idx=0",
                     anode_o, data_o, blank_o, value_ready_o, digit_idx_o);
        end
    endtask

    task automatic test_load_scan();
        bit to;
        logic [15:0] w;
        logic [3:0] wantAnode;
        w = 16'h1A2F;
        load_word(w, to);
        total++;
        if (value_ready_o !== 1'b0 || to) begin
            bad++;
            $display("[TB] FAIL load_ready_drop: got ready=%b timeout=%0d, want ready=0 timeout=0", value_ready_o, to);
        end
        wait_wrap(to);
        @(negedge clk);
        total++;
        if (value_ready_o !== 1'b1 || to) begin
            bad++;
            $display("[TB] FAIL load_ready_return: got ready=%b timeout=%0d, want ready=1 timeout=0", value_ready_o, to);
        end
        for (int d = 0; d < N; d++) begin
            wantAnode = 4'hF ^ (4'h1 << d);
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                total++;
                if ({data_o, anode_o, blank_o} !== {nibbleOf(w, d), wantAnode, 1'b0}) begin
                    bad++;
                    $display("[TB] FAIL scan_digit%0d: got data=%h anode=%b blank=%b, want data=%h anode=%b blank=0",
                             d, data_o, anode_o, blank_o, nibbleOf(w, d), wantAnode);
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [15:0] words [3] = '{16'h0005, 16'h0000, 16'h0005};
        logic        lzs   [3] = '{1'b1, 1'b1, 1'b0};
        bit to;
        logic [3:0] wantData, wantAnode;
        logic wantBlank;
        for (int s = 0; s < 3; s++) begin
            blank_lz_i = lzs[s];
            load_word(words[s], to);
            wait_wrap(to);
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                wantBlank = lzs[s] && d != 0 && (words[s] >> (4 * d)) == 16'h0;
                wantData  = wantBlank ? 4'h0 : nibbleOf(words[s], d);
                wantAnode = wantBlank ? 4'hF : 4'hF ^ (4'h1 << d);
                for (int c = 0; c < DIV; c++) begin
                    @(negedge clk);
                    total++;
                    if ({data_o, anode_o, blank_o} !== {wantData, wantAnode, wantBlank} || to) begin
                        bad++;
                        $display("[TB] FAIL blank_case%0d_digit%0d: got data=%h anode=%b blank=%b, want data=%h anode=%b blank=%b",
                                 s, d, data_o, anode_o, blank_o, wantData, wantAnode, wantBlank);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        bit started = 1'b0;
        bit sawTwo  = 1'b0;
        bit accepted = 1'b0;
        logic [3:0] frameVal = 4'h0;
        logic [1:0] prevIdx = 2'd0;
        blank_lz_i = 1'b0;
        load_word(16'h1111, to);
        value_i = 16'h2222;
        value_valid_i = 1'b1;
        for (int g = 0; g < 100 && !accepted; g++) begin
            total++;
            if ({value_ready_o, data_o} !== {expReady, expData}) begin
                bad++;
                $display("[TB] FAIL hold_valid: got ready=%b data=%h, want ready=%b data=%h",
                         value_ready_o, data_o, expReady, expData);
            end
            if (value_ready_o === 1'b1) accepted = 1'b1;
            @(negedge clk);
        end
        value_valid_i = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (digit_idx_o == 2'd0 && prevIdx == 2'd3) begin
                started  = 1'b1;
                frameVal = data_o;
                if (data_o == 4'h2) sawTwo = 1'b1;
                total++;
                if (data_o !== 4'h1 && data_o !== 4'h2) begin
                    bad++;
                    $display("[TB] FAIL frame_value: got data=%h, want 1 or 2", data_o);
                end
            end else if (started) begin
                total++;
                if (data_o !== frameVal) begin
                    bad++;
                    $display("[TB] FAIL frame_tear: got data=%h at digit %0d, want %h", data_o, digit_idx_o, frameVal);
                end
            end
            prevIdx = digit_idx_o;
        end
        total++;
        if (!accepted || !sawTwo) begin
            bad++;
            $display("[TB] FAIL b2b_accept: got accepted=%0d shown=%0d, want accepted=1 shown=1", accepted, sawTwo);
        end
    endtask

    task automatic test_coincident();
        bit to;
        wait_wrap(to);
        total++;
        if (value_ready_o !== 1'b1 || to) begin
            bad++;
            $display("[TB] FAIL coinc_ready: got ready=%b timeout=%0d, want ready=1 timeout=0", value_ready_o, to);
        end
        value_i = 16'h3333;
        value_valid_i = 1'b1;
        @(negedge clk);
        value_valid_i = 1'b0;
        for (int c = 0; c < 2 * N * DIV; c++) begin
            @(negedge clk);
            total++;
            if (data_o !== ((c < N * DIV) ? 4'h2 : 4'h3)) begin
                bad++;
                $display("[TB] FAIL coinc_frame%0d: got data=%h, want %h", c / (N * DIV), data_o,
                         (c < N * DIV) ? 4'h2 : 4'h3);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit found = 1'b0;
        load_word(16'h1234, to);
        wait_wrap(to);
        @(negedge clk);
        load_word(16'h5678, to);
        for (int g = 0; g < 40 && !found; g++) begin
            if (digit_idx_o == 2'd2) found = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!found || data_o !== 4'h2) begin
            bad++;
            $display("[TB] FAIL mid_digit2: got found=%0d data=%h, want found=1 data=2", found, data_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({anode_o, data_o, blank_o, value_ready_o, digit_idx_o} !== {4'hF, 4'h0, 1'b1, 1'b0, 2'd0}) begin
            bad++;
            $display("[TB] FAIL mid_reset: got anode=%b data=%h blank=%b ready=%b idx=%0d, want anode=1111 data=0 blank=1 ready=0 idx=0",
                     anode_o, data_o, blank_o, value_ready_o, digit_idx_o);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3 * N * DIV; c++) begin
            @(negedge clk);
            total++;
            if (data_o !== 4'h0 || blank_o !== 1'b0 || (c == 0 && anode_o !== 4'b1110)) begin
                bad++;
                $display("[TB] FAIL mid_restart: got data=%h blank=%b anode=%b, want data=0 blank=0", data_o, blank_o, anode_o);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int c = 0; c < 400; c++) begin
            w = 16'($urandom);
            value_i       = w >> (4 * $urandom_range(0, 3));
            value_valid_i = ($urandom_range(0, 3) == 0);
            blank_lz_i    = ($urandom_range(0, 1) == 1);
            rst_n         = ($urandom_range(0, 99) != 0);
            @(negedge clk);
            total++;
            if ({value_ready_o, anode_o, data_o, blank_o, digit_idx_o} !==
                {expReady, expAnode, expData, expBlank, expIdx}) begin
                bad++;
                $display("[TB] FAIL random_model: got ready=%b anode=%b data=%h blank=%b idx=%0d, want ready=%b anode=%b data=%h blank=%b idx=%0d",
                         value_ready_o, anode_o, data_o, blank_o, digit_idx_o,
                         expReady, expAnode, expData, expBlank, expIdx);
            end
        end
        rst_n = 1'b1;
        value_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_scan();
        test_blanking();
        test_back_to_back();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
